// File: rtl/jt12_eg_cfg.sv
// Per-slot envelope parameter store: accepts register writes via req/ack and replays
// each slot's rates, sustain level, SSG-EG mode and key-on bit in slot order, one slot per clk_en.
module jt12_eg_cfg #(
   parameter int num_ch = 6
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       clk_en,
   input  logic       wr_req,
   input  logic [4:0] wr_slot,
   input  logic [2:0] wr_field,
   input  logic [7:0] wr_data,
   output logic       wr_ack,
   output logic       zero,
   output logic [4:0] arate_I,
   output logic [4:0] rate1_I,
   output logic [4:0] rate2_I,
   output logic [3:0] rrate_I,
   output logic [3:0] sl_I,
   output logic       ssg_en_I,
   output logic [2:0] ssg_eg_I,
   output logic       keyon_I,
   output logic [1:0] ks_II
);
   localparam int S = 4 * num_ch;
   localparam logic [5:0] S_W  = 6'(S);
   localparam logic [5:0] CH_W = 6'(num_ch);

   typedef enum logic [1:0] {IDLE, WAIT, ACK, HOLD} state_t;
   state_t state, state_nx;

   logic [4:0] cur;
   logic [2:0] cur_ch;
   logic [1:0] cur_op;

   logic [4:0] arate_a  [S];
   logic [4:0] rate1_a  [S];
   logic [4:0] rate2_a  [S];
   logic [3:0] rrate_a  [S];
   logic [3:0] sl_a     [S];
   logic [1:0] ks_a     [S];
   logic       ssg_en_a [S];
   logic [2:0] ssg_eg_a [S];
   logic [3:0] kon      [num_ch];

   logic slot_ok, ch_ok, can_take, accept, slot_wr, kon_wr;

   assign slot_ok  = ({1'b0, wr_slot} < S_W);
   assign ch_ok    = ({1'b0, wr_slot} < CH_W);
   assign can_take = clk_en && wr_req && (state == IDLE || state == WAIT);
   // Slot fields wait for their slot to come round; key-on, reserved fields and
   // out-of-range targets complete on the first enabled cycle.
   assign accept   = can_take && ((wr_field >= 3'd5) || !slot_ok || (wr_slot == cur));
   assign slot_wr  = accept && (wr_field <= 3'd4) && slot_ok;
   assign kon_wr   = accept && (wr_field == 3'd5) && ch_ok;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cur    <= '0;
         cur_ch <= '0;
         cur_op <= '0;
         ks_II  <= '0;
      end else if (clk_en) begin
         ks_II <= ks_a[cur];
         if (cur == 5'(S - 1)) begin
            cur    <= '0;
            cur_ch <= '0;
            cur_op <= '0;
         end else begin
            cur <= cur + 5'd1;
            if (cur_ch == 3'(num_ch - 1)) begin
               cur_ch <= '0;
               cur_op <= cur_op + 2'd1;
            end else begin
               cur_ch <= cur_ch + 3'd1;
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < S; i++) begin
            arate_a[i]  <= '0;
            rate1_a[i]  <= '0;
            rate2_a[i]  <= '0;
            rrate_a[i]  <= '0;
            sl_a[i]     <= '0;
            ks_a[i]     <= '0;
            ssg_en_a[i] <= 1'b0;
            ssg_eg_a[i] <= '0;
         end
      end else if (slot_wr) begin
         case (wr_field)
            3'd0: begin
               arate_a[cur] <= wr_data[4:0];
               ks_a[cur]    <= wr_data[7:6];
            end
            3'd1: rate1_a[cur] <= wr_data[4:0];
            3'd2: rate2_a[cur] <= wr_data[4:0];
            3'd3: begin
               sl_a[cur]    <= wr_data[7:4];
               rrate_a[cur] <= wr_data[3:0];
            end
            3'd4: begin
               ssg_en_a[cur] <= wr_data[3];
               ssg_eg_a[cur] <= wr_data[2:0];
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < num_ch; i++) kon[i] <= '0;
      end else if (kon_wr) begin
         kon[wr_slot[2:0]] <= wr_data[3:0];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      wr_ack   = 1'b0;
      case (state)
         IDLE: begin
            if (accept)      state_nx = ACK;
            else if (wr_req) state_nx = WAIT;
         end
         WAIT: if (accept) state_nx = ACK;
         ACK: begin
            wr_ack   = 1'b1;
            state_nx = HOLD;
         end
         HOLD: if (!wr_req) state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   assign zero     = (cur == 5'd0);
   assign arate_I  = arate_a[cur];
   assign rate1_I  = rate1_a[cur];
   assign rate2_I  = rate2_a[cur];
   assign rrate_I  = rrate_a[cur];
   assign sl_I     = sl_a[cur];
   assign ssg_en_I = ssg_en_a[cur];
   assign ssg_eg_I = ssg_eg_a[cur];
   assign keyon_I  = kon[cur_ch][cur_op];
endmodule

// File: tb/tb_jt12_eg_cfg.sv
// Directed bench for jt12_eg_cfg with num_ch=6 (24 slots).
module tb_jt12_eg_cfg;
   localparam int S = 24;

   logic       clk = 1'b0, rst_n = 1'b0, clk_en = 1'b0, wr_req = 1'b0;
   logic [4:0] wr_slot = '0;
   logic [2:0] wr_field = '0;
   logic [7:0] wr_data = '0;
   logic       wr_ack, zero, ssg_en_I, keyon_I;
   logic [4:0] arate_I, rate1_I, rate2_I;
   logic [3:0] rrate_I, sl_I;
   logic [2:0] ssg_eg_I;
   logic [1:0] ks_II;
   logic [27:0] stg;

   int n_chk = 0, n_fail = 0;
   int tb_cur;
   int n;

   jt12_eg_cfg #(.num_ch(6)) dut (
      .clk(clk), .rst_n(rst_n), .clk_en(clk_en),
      .wr_req(wr_req), .wr_slot(wr_slot), .wr_field(wr_field), .wr_data(wr_data),
      .wr_ack(wr_ack), .zero(zero),
      .arate_I(arate_I), .rate1_I(rate1_I), .rate2_I(rate2_I), .rrate_I(rrate_I),
      .sl_I(sl_I), .ssg_en_I(ssg_en_I), .ssg_eg_I(ssg_eg_I), .keyon_I(keyon_I),
      .ks_II(ks_II)
   );

   assign stg = {arate_I, rate1_I, rate2_I, rrate_I, sl_I, ssg_en_I, ssg_eg_I, keyon_I};

   always #5 clk = ~clk;

   // Expected slot position, used to place requests at known slots.
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n)      tb_cur <= 0;
      else if (clk_en) tb_cur <= (tb_cur == S - 1) ? 0 : tb_cur + 1;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not reach the end, got timeout expected finish");
      $fatal(1);
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic go_to(input int s);
      int k = 0;
      while (tb_cur != s && k < 200) begin
         step();
         k++;
      end
      if (tb_cur != s) check("go_to_timeout", tb_cur, s);
   endtask

   task automatic wait_ack(output int cnt);
      cnt = 0;
      while (!wr_ack && cnt < 100) begin
         step();
         cnt++;
      end
      check("ack_seen", wr_ack, 1'b1);
   endtask

   task automatic req(input logic [2:0] f, input logic [4:0] s, input logic [7:0] d);
      wr_field = f;
      wr_slot  = s;
      wr_data  = d;
      wr_req   = 1'b1;
   endtask

   initial begin
      // Reset state
      repeat (3) @(posedge clk);
      #1;
      check("rst_zero", zero, 1'b1);
      check("rst_stage1", stg, 28'd0);
      check("rst_ack", wr_ack, 1'b0);
      check("rst_ks2", ks_II, 2'd0);
      #2 rst_n = 1'b1;
      clk_en = 1'b1;

      // Free-running rotation: zero at 0, S, 2S
      for (int i = 0; i <= 2 * S; i++) begin
         check("zero_rot", zero, (i % S) == 0);
         check("stage1_idle", stg, 28'd0);
         check("ack_idle", wr_ack, 1'b0);
         step();
      end

      // Field 0 to slot 7 issued at slot 9: waits 22 slots past the issue cycle
      go_to(9);
      req(3'd0, 5'd7, 8'hDF);
      wait_ack(n);
      check("f0_edges_to_ack", n, 23);
      check("f0_ack_slot", tb_cur, 8);
      wr_req = 1'b0;
      step();
      check("f0_ack_pulse", wr_ack, 1'b0);
      go_to(6);
      check("f0_neighbour", arate_I, 5'd0);
      step();
      check("f0_arate", arate_I, 5'd31);
      check("f0_ks2_before", ks_II, 2'd0);
      step();
      check("f0_ks2", ks_II, 2'd3);
      check("f0_arate_next", arate_I, 5'd0);

      // Field 3 to slot 0 issued at slot 0: accepted at once, old value shown that cycle
      go_to(0);
      req(3'd3, 5'd0, 8'h5A);
      check("f3_old_sl", sl_I, 4'd0);
      check("f3_old_rr", rrate_I, 4'd0);
      step();
      check("f3_ack", wr_ack, 1'b1);
      wr_req = 1'b0;
      go_to(0);
      check("f3_sl", sl_I, 4'd5);
      check("f3_rrate", rrate_I, 4'd10);

      // Key-on channel 2 mask 1001: ops 0 and 3 -> slots 2 and 20
      req(3'd5, 5'd2, 8'h09);
      step();
      check("f5_ack", wr_ack, 1'b1);
      wr_req = 1'b0;
      go_to(2);
      check("kon_s2", keyon_I, 1'b1);
      go_to(8);
      check("kon_s8", keyon_I, 1'b0);
      go_to(14);
      check("kon_s14", keyon_I, 1'b0);
      go_to(20);
      check("kon_s20", keyon_I, 1'b1);

      // Sparse clk_en, then reset while the write is pending
      go_to(10);
      clk_en = 1'b0;
      req(3'd2, 5'd5, 8'h11);
      for (int i = 0; i < 12; i++) begin
         clk_en = ((i % 4) == 0);
         step();
         check("slow_noack", wr_ack, 1'b0);
      end
      rst_n  = 1'b0;
      wr_req = 1'b0;
      #2;
      check("midrst_zero", zero, 1'b1);
      check("midrst_ack", wr_ack, 1'b0);
      check("midrst_stage1", stg, 28'd0);
      #1 rst_n = 1'b1;
      clk_en = 1'b1;
      go_to(5);
      check("midrst_rate2", rate2_I, 5'd0);
      req(3'd2, 5'd5, 8'h11);
      wait_ack(n);
      check("reissue_edges", n, 1);
      wr_req = 1'b0;
      go_to(5);
      check("reissue_rate2", rate2_I, 5'h11);

      // Out-of-range slot and reserved field: ack after one clk_en, no re-execution while held
      step();
      req(3'd1, 5'd30, 8'hFF);
      wait_ack(n);
      check("slot30_edges", n, 1);
      for (int i = 0; i < 4; i++) begin
         step();
         check("hold_noack", wr_ack, 1'b0);
      end
      wr_req = 1'b0;
      step();
      req(3'd7, 5'd3, 8'hFF);
      wait_ack(n);
      check("field7_edges", n, 1);
      wr_req = 1'b0;
      step();

      // Full rotation: only slot 5 rate2 programmed since the reset
      go_to(0);
      for (int s = 0; s < S; s++) begin
         logic [27:0] e;
         e = '0;
         if (s == 5) e[17:13] = 5'h11;
         check("final_rot", stg, e);
         step();
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
